// File: rtl/bus_chain_pkg.sv
// Shared definitions for the bus combining chain.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: combine-mode encodings, the combine operator op() and the
// occupancy counter width helper.
package bus_chain_pkg;

  // Combine-mode encodings, selected by the MODE parameter.
  localparam int MODE_XOR = 0;
  localparam int MODE_AND = 1;
  localparam int MODE_OR  = 2;
  localparam int MODE_ADD = 3;

  // op() works on a fixed wide word. Callers zero-extend their operands
  // and keep the low WIDTH bits of the result. For ADD this yields the
  // sum modulo 2^WIDTH, because the low bits of a sum do not depend on
  // the high bits of its operands. WIDTH must not exceed OP_W.
  localparam int OP_W = 64;

  function automatic logic [OP_W-1:0] op(input logic [OP_W-1:0] x,
                                         input logic [OP_W-1:0] y,
                                         input int              mode);
    logic [OP_W-1:0] r;
    case (mode)
      MODE_AND: r = x & y;
      MODE_OR:  r = x | y;
      MODE_ADD: r = x + y;
      default:  r = x ^ y;
    endcase
    return r;
  endfunction

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bus_chain_stage.sv
// One registered slice of the combining chain: valid, accumulator and b operand.
// Latency: 1 cycle from upstream beat to dn_vld.
// Backpressure: up_rdy = !valid | dn_rdy (combinational pass-through, no skid).
//
// Ports: clk/reset (synchronous, active-high); flush clears the valid bit only.
//   up_vld/up_acc/up_b/up_rdy  : upstream beat and the ready returned to it.
//   dn_vld/dn_acc/dn_b/dn_rdy  : registered beat toward the next stage.
//   vld_nxt                    : next-cycle valid, used for the occupancy count.
module bus_chain_stage
  import bus_chain_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_acc,
  input  logic [WIDTH-1:0] up_b,
  output logic             up_rdy,
  output logic             dn_vld,
  output logic [WIDTH-1:0] dn_acc,
  output logic [WIDTH-1:0] dn_b,
  input  logic             dn_rdy,
  output logic             vld_nxt
);

  logic             vld_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_nxt;
  logic             load;

  // The slice can take a beat when it is empty, or when its own beat
  // leaves downstream in the same cycle.
  assign up_rdy = !vld_q | dn_rdy;

  // Flush drops the beat but leaves the data registers alone, so the
  // output keeps showing the last value while empty.
  assign vld_nxt = flush ? 1'b0 : (up_rdy ? up_vld : vld_q);
  assign load    = up_vld & up_rdy & !flush;

  assign acc_nxt = WIDTH'(op(OP_W'(up_acc), OP_W'(up_b), MODE));

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= vld_nxt;
      if (load) begin
        acc_q <= acc_nxt;
        b_q   <= up_b;
      end
    end
  end

  assign dn_vld = vld_q;
  assign dn_acc = acc_q;
  assign dn_b   = b_q;

endmodule

// File: rtl/bus_chain_pipe.sv
// Combines in_a and in_b through DEPTH registered stages; result = in_a op in_b applied DEPTH times.
// Latency: DEPTH cycles from accept to out_valid; one beat per cycle when unstalled.
// Backpressure: valid/ready; in_ready follows out_ready combinationally through the chain.
//
// Ports: clk, reset (synchronous, active-high); in_a/in_b/in_valid/in_ready input beat;
//   flush discards every in-flight beat; out_data/out_valid/out_ready output beat;
//   occupancy is the registered count of valid stages.
module bus_chain_pipe
  import bus_chain_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  // Chain nets: index k is the input side of stage k, index DEPTH the output.
  logic [DEPTH:0]   vld_c;
  logic [DEPTH:0]   rdy_c;
  logic [WIDTH-1:0] acc_c [0:DEPTH];
  logic [WIDTH-1:0] b_c   [0:DEPTH];
  logic [DEPTH-1:0] vld_nxt;
  logic [OCC_W-1:0] occ_nxt;
  logic             unused_b_tail;

  // A beat offered during flush is refused; gating the head valid keeps
  // it out of stage 0 as well.
  assign vld_c[0]     = in_valid & !flush;
  assign acc_c[0]     = in_a;
  assign b_c[0]       = in_b;
  assign rdy_c[DEPTH] = out_ready;

  assign in_ready  = rdy_c[0] & !flush;
  assign out_valid = vld_c[DEPTH];
  assign out_data  = acc_c[DEPTH];

  // The last stage's b operand has no consumer.
  assign unused_b_tail = ^b_c[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    bus_chain_stage #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .up_vld  (vld_c[k]),
      .up_acc  (acc_c[k]),
      .up_b    (b_c[k]),
      .up_rdy  (rdy_c[k]),
      .dn_vld  (vld_c[k+1]),
      .dn_acc  (acc_c[k+1]),
      .dn_b    (b_c[k+1]),
      .dn_rdy  (rdy_c[k+1]),
      .vld_nxt (vld_nxt[k])
    );
  end

  // Popcount of the next-cycle valid bits, so the registered count lands
  // on the same edge as the valids it describes.
  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_bus_chain_pipe.sv
// Bench for bus_chain_pipe: three instances (ADD depth 2, XOR depth 2, XOR depth 3)
// share one stimulus stream. A queue-based model predicts each instance's output
// sequence and occupancy, and directed steps check latency and boundary cases.
module tb_bus_chain_pipe;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       flush     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] in_a      = '0;
  logic [1:0] in_b      = '0;

  logic       in_rdy [3];
  logic       o_vld  [3];
  logic [1:0] o_dat  [3];
  logic [1:0] occ    [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_chain_pipe #(.WIDTH(2), .DEPTH(2), .MODE(3)) dut_add2 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_rdy[0]), .flush(flush), .out_data(o_dat[0]), .out_valid(o_vld[0]),
    .out_ready(out_ready), .occupancy(occ[0]));

  bus_chain_pipe #(.WIDTH(2), .DEPTH(2), .MODE(0)) dut_xor2 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_rdy[1]), .flush(flush), .out_data(o_dat[1]), .out_valid(o_vld[1]),
    .out_ready(out_ready), .occupancy(occ[1]));

  bus_chain_pipe #(.WIDTH(2), .DEPTH(3), .MODE(0)) dut_xor3 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_rdy[2]), .flush(flush), .out_data(o_dat[2]), .out_valid(o_vld[2]),
    .out_ready(out_ready), .occupancy(occ[2]));

  function automatic int dut_mode(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  function automatic int dut_depth(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  // Result of a beat: apply "acc = acc op b" depth times starting from a, 2-bit wrap.
  function automatic logic [1:0] model(input int a, input int b, input int mode, input int depth);
    int acc;
    acc = a;
    for (int k = 0; k < depth; k++) begin
      case (mode)
        0:       acc = acc ^ b;
        1:       acc = acc & b;
        2:       acc = acc | b;
        default: acc = (acc + b) % 4;
      endcase
    end
    return 2'(acc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: each queue holds the expected results of the beats in flight,
  // oldest first. Its size is the expected occupancy.
  int unsigned q [3][$];
  logic        prev_hold [3];
  logic [1:0]  prev_dat  [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        q[i].delete();
        prev_hold[i] = 1'b0;
      end else begin
        chk($sformatf("occ_model%0d", i), 32'(occ[i]), 32'(q[i].size()));
        if (prev_hold[i]) begin
          chk($sformatf("hold_vld%0d", i), 32'(o_vld[i]), 32'd1);
          chk($sformatf("hold_dat%0d", i), 32'(o_dat[i]), 32'(prev_dat[i]));
        end
        if (o_vld[i] && out_ready) begin
          chk($sformatf("out_pending%0d", i), 32'(q[i].size() > 0), 32'd1);
          if (q[i].size() > 0) begin
            chk($sformatf("out_data%0d", i), 32'(o_dat[i]), q[i].pop_front());
          end
        end
        prev_hold[i] = o_vld[i] & !out_ready & !flush;
        prev_dat[i]  = o_dat[i];
        if (flush) begin
          q[i].delete();
        end else if (in_valid && in_rdy[i]) begin
          q[i].push_back(32'(model(in_a, in_b, dut_mode(i), dut_depth(i))));
        end
      end
    end
  end

  initial begin
    // Reset held for three cycles.
    step(3);
    chk("rst_out_valid", 32'(o_vld[0]), 32'd0);
    chk("rst_out_data",  32'(o_dat[0]), 32'd0);
    chk("rst_occ",       32'(occ[0]),   32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_rdy[0]), 32'd1);

    // Latency: ADD 1+1 twice = 3, valid exactly two edges after accept.
    in_a = 2'd1; in_b = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("lat_e1_vld", 32'(o_vld[0]), 32'd0);
    step(1);
    chk("lat_e2_vld", 32'(o_vld[0]), 32'd1);
    chk("lat_e2_dat", 32'(o_dat[0]), 32'd3);
    step(3);

    // Wrap and mode checks: (3,3) then (2,1).
    in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3;
    step(1);
    in_a = 2'd2; in_b = 2'd1;
    step(1);
    in_valid = 1'b0;
    chk("wrap_add_vld", 32'(o_vld[0]), 32'd1);
    chk("wrap_add_dat", 32'(o_dat[0]), 32'd1);
    step(1);
    chk("add_2_1",  32'(o_dat[0]), 32'(model(2, 1, 3, 2)));
    chk("xor2_2_1", 32'(o_dat[1]), 32'd2);
    step(1);
    chk("xor3_2_1_vld", 32'(o_vld[2]), 32'd1);
    chk("xor3_2_1",     32'(o_dat[2]), 32'd3);
    step(3);

    // Backpressure: depth-2 chain takes two beats, refuses the third.
    out_ready = 1'b0; in_valid = 1'b1; in_b = 2'd0; in_a = 2'd0;
    step(1);
    in_a = 2'd1;
    step(1);
    in_a = 2'd2;
    #1;
    chk("bp_in_ready_full", 32'(in_rdy[0]), 32'd0);
    chk("bp_occ_full",      32'(occ[0]),    32'd2);
    step(1);
    chk("bp_occ_stall", 32'(occ[0]), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_head_vld",  32'(o_vld[0]),  32'd1);
    chk("bp_head_dat",  32'(o_dat[0]),  32'd0);
    chk("bp_in_ready",  32'(in_rdy[0]), 32'd1);
    step(1);
    in_valid = 1'b0;
    chk("bp_second_dat", 32'(o_dat[0]), 32'd1);
    chk("bp_pushpop_occ", 32'(occ[0]), 32'd2);
    step(1);
    chk("bp_third_vld", 32'(o_vld[0]), 32'd1);
    chk("bp_third_dat", 32'(o_dat[0]), 32'd2);
    step(1);
    chk("bp_empty_vld",  32'(o_vld[0]), 32'd0);
    chk("bp_empty_occ",  32'(occ[0]),   32'd0);
    chk("bp_empty_hold", 32'(o_dat[0]), 32'd2);
    step(4);

    // Streaming: 8 back-to-back beats leave on 8 consecutive cycles.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        in_a = 2'($urandom_range(0, 3));
        in_b = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      step(1);
      chk($sformatf("stream_vld%0d", k), 32'(o_vld[0]), 32'(k >= 1 && k <= 8));
    end
    step(3);

    // Flush with two beats in flight and a beat on offer.
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 2'($urandom_range(0, 3)); in_b = 2'($urandom_range(0, 3));
    step(2);
    chk("fl_occ_before", 32'(occ[0]), 32'd2);
    in_a = 2'd1; in_b = 2'd1; flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_rdy[0]), 32'd0);
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ_after", 32'(occ[0]), 32'd0);
    chk("fl_vld_after", 32'(o_vld[0]), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk($sformatf("fl_no_out%0d", k), 32'(o_vld[0]), 32'd0);
    end

    // Reset while full and stalled, then one clean beat.
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 2'($urandom_range(0, 3)); in_b = 2'($urandom_range(0, 3));
    step(3);
    chk("mr_occ_full", 32'(occ[0]),    32'd2);
    chk("mr_in_ready", 32'(in_rdy[0]), 32'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0; in_valid = 1'b0;
    chk("mr_vld", 32'(o_vld[0]), 32'd0);
    chk("mr_dat", 32'(o_dat[0]), 32'd0);
    chk("mr_occ", 32'(occ[0]),   32'd0);
    in_valid = 1'b1; in_a = 2'd1; in_b = 2'd2; out_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("mr_post_e1_vld", 32'(o_vld[0]), 32'd0);
    step(1);
    chk("mr_post_e2_vld", 32'(o_vld[0]), 32'd1);
    chk("mr_post_e2_dat", 32'(o_dat[0]), 32'(model(1, 2, 3, 2)));
    step(3);

    // Random traffic with stalls and occasional flushes; the scoreboard checks it.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_a      = 2'($urandom_range(0, 3));
      in_b      = 2'($urandom_range(0, 3));
      step(1);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
